// File: rtl/snn_current_scheduler_if.sv
// Calculator-side bus of the SNN current scheduler: latched spikes,
// enable and neuron select out, saturated current back.
interface snn_current_scheduler_if #(
    parameter int M     = 24,
    parameter int SEL_W = 3
);
    logic [M-1:0]     spikes_latched;
    logic             calc_enable;
    logic [SEL_W-1:0] neuron_sel;
    logic signed [7:0] calc_current;

    modport master (
        output spikes_latched,
        output calc_enable,
        output neuron_sel,
        input  calc_current
    );

    modport slave (
        input  spikes_latched,
        input  calc_enable,
        input  neuron_sel,
        output calc_current
    );
endinterface

// File: rtl/snn_current_scheduler.sv
// Time-multiplexes one input-current calculator across N neurons,
// collecting one signed 8-bit result per neuron per timestep.
module snn_current_scheduler #(
    parameter int N = 8,
    parameter int M = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [M-1:0]   spikes_in,
    output logic [N*8-1:0] currents,
    output logic           busy,
    output logic           done,
    snn_current_scheduler_if.master calc
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] idx_q;
    logic [M-1:0]     spikes_q;
    logic             calc_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An all-zero spike vector cannot produce current, so skip the calculator.
    always_comb begin
        state_d = state_q;
        calc_en = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (spikes_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                calc_en = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = (idx_q == LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            spikes_q <= '0;
            currents <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                spikes_q <= spikes_in;
                idx_q    <= '0;
                if (spikes_in == '0) begin
                    currents <= '0;
                end
            end
            if (state_q == CAPTURE) begin
                for (int n = 0; n < N; n++) begin
                    if (idx_q == SEL_W'(n)) begin
                        currents[n*8 +: 8] <= calc.calc_current;
                    end
                end
                // idx stays on the last neuron until the next accepted start.
                if (idx_q != LAST) begin
                    idx_q <= idx_q + SEL_W'(1);
                end
            end
        end
    end

    assign calc.calc_enable    = calc_en;
    assign calc.neuron_sel     = idx_q;
    assign calc.spikes_latched = spikes_q;
endmodule
